// File: rtl/mii_mac_tx_pkg.sv
// Shared constants and state encoding for the MII MAC transmit path.
// The CRC residue is kept here so that a future receiver can share it.
package mii_mac_tx_pkg;

    localparam logic [3:0]  DATA_PREAMBLE   = 4'h5;
    localparam logic [3:0]  DATA_SFD        = 4'hD;
    localparam logic [3:0]  DATA_JAM        = 4'h5;

    localparam logic [31:0] CRC32_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DLO,
        S_DHI,
        S_PLO,
        S_PHI,
        S_FCS,
        S_JAM,
        S_UFL,
        S_DISC,
        S_IFG
    } tx_state_t;

endpackage

// File: rtl/mii_mac_tx_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, LSB first.
// Holds no state, so the receive path can reuse it directly.
module crc32_nibble
    import mii_mac_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    logic [31:0] w_c;

    always_comb begin
        w_c = crc_in;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_c[0] ^ nibble[i]) begin
                w_c = (w_c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_c = w_c >> 1;
            end
        end
        crc_out = w_c;
    end

endmodule

// File: rtl/mii_mac_tx.sv
// MAC-side MII transmitter: preamble/SFD, padding, FCS, IFG, and jam on collision.
// Every MII output is registered; the FSM decides the nibble one cycle before it is driven.
module mii_mac_tx
    import mii_mac_tx_pkg::*;
#(
    parameter int unsigned MIN_DATA    = 60,
    parameter int unsigned IFG_NIBBLES = 24,
    parameter int unsigned JAM_NIBBLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    input  logic       err,
    output logic       ready,
    input  logic       col,
    output logic       tx_en,
    output logic       tx_er,
    output logic [3:0] txd,
    output logic       sent,
    output logic       collision,
    output logic       underflow
);

    localparam logic [7:0]  PRE_LAST = 8'd14;
    localparam logic [7:0]  FCS_LAST = 8'd7;
    localparam logic [7:0]  JAM_LAST = 8'(JAM_NIBBLES - 1);
    localparam logic [7:0]  IFG_N    = 8'(IFG_NIBBLES);
    localparam logic [10:0] MIN_B    = 11'(MIN_DATA);

    tx_state_t   r_state, w_next;
    logic [7:0]  r_cnt, w_cnt;
    logic [7:0]  r_ifg;
    logic [10:0] r_bcnt;
    logic [7:0]  r_byte;
    logic        r_berr;
    logic        r_last;
    logic [31:0] r_crc, w_crc_nxt;

    logic        r_tx_en, r_tx_er, r_sent, r_coll, r_ufl;
    logic [3:0]  r_txd;

    logic        w_en, w_er, w_sent, w_coll, w_ufl, w_rdy, w_crc_en;
    logic        w_abortable, w_col_ev, w_ufl_ev, w_acc;
    logic [3:0]  w_d;

    crc32_nibble u_crc (
        .crc_in  (r_crc),
        .nibble  (w_d),
        .crc_out (w_crc_nxt)
    );

    always_comb begin
        w_next      = r_state;
        w_en        = 1'b0;
        w_er        = 1'b0;
        w_d         = '0;
        w_sent      = 1'b0;
        w_coll      = 1'b0;
        w_ufl       = 1'b0;
        w_rdy       = 1'b0;
        w_crc_en    = 1'b0;
        w_abortable = 1'b0;
        unique case (r_state)
            S_IDLE: if (valid) w_next = S_PRE;
            S_PRE: begin
                w_en = 1'b1; w_d = DATA_PREAMBLE; w_abortable = 1'b1;
                if (r_cnt == PRE_LAST) w_next = S_SFD;
            end
            S_SFD: begin
                w_en = 1'b1; w_d = DATA_SFD; w_abortable = 1'b1;
                w_rdy = 1'b1; w_next = S_DLO;
            end
            S_DLO: begin
                w_en = 1'b1; w_d = r_byte[3:0]; w_er = r_berr;
                w_crc_en = 1'b1; w_abortable = 1'b1; w_next = S_DHI;
            end
            S_DHI: begin
                // The next byte is fetched while this byte's high nibble goes out.
                w_en = 1'b1; w_d = r_byte[7:4]; w_er = r_berr;
                w_crc_en = 1'b1; w_abortable = 1'b1; w_rdy = !r_last;
                if (r_last) w_next = (r_bcnt < MIN_B) ? S_PLO : S_FCS;
                else        w_next = S_DLO;
            end
            S_PLO: begin
                w_en = 1'b1; w_crc_en = 1'b1; w_abortable = 1'b1; w_next = S_PHI;
            end
            S_PHI: begin
                w_en = 1'b1; w_crc_en = 1'b1; w_abortable = 1'b1;
                w_next = (r_bcnt >= MIN_B - 11'd1) ? S_FCS : S_PLO;
            end
            S_FCS: begin
                w_en = 1'b1; w_d = ~r_crc[3:0]; w_abortable = 1'b1;
                if (r_cnt == FCS_LAST) begin
                    w_next = S_IFG; w_sent = 1'b1;
                end
            end
            S_JAM: begin
                w_en = 1'b1; w_d = DATA_JAM; w_coll = (r_cnt == '0);
                if (r_cnt == JAM_LAST) w_next = r_last ? S_IFG : S_DISC;
            end
            S_UFL: begin
                w_en = 1'b1; w_er = 1'b1; w_ufl = 1'b1;
                w_next = r_last ? S_IFG : S_DISC;
            end
            S_DISC: begin
                w_rdy = 1'b1;
                if (valid && last) w_next = (r_ifg <= 8'd1) ? S_IDLE : S_IFG;
            end
            S_IFG: if (r_ifg <= 8'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        w_col_ev = col && w_abortable;
        w_ufl_ev = w_rdy && !valid && (r_state == S_SFD || r_state == S_DHI);
        if (w_col_ev) begin
            w_next = S_JAM;
            w_sent = 1'b0;
        end else if (w_ufl_ev) begin
            w_next = S_UFL;
        end
        w_cnt = (w_next != r_state) ? '0 : r_cnt + 8'd1;
        w_acc = valid && w_rdy;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ifg   <= '0;
            r_bcnt  <= '0;
            r_byte  <= '0;
            r_berr  <= 1'b0;
            r_last  <= 1'b0;
            r_crc   <= CRC32_INIT;
            r_tx_en <= 1'b0;
            r_tx_er <= 1'b0;
            r_txd   <= '0;
            r_sent  <= 1'b0;
            r_coll  <= 1'b0;
            r_ufl   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_tx_en <= w_en;
            r_tx_er <= w_er;
            r_txd   <= w_d;
            r_sent  <= w_sent;
            r_coll  <= w_coll;
            r_ufl   <= w_ufl;

            if (r_state == S_IDLE)     r_crc <= CRC32_INIT;
            else if (r_state == S_FCS) r_crc <= {4'h0, r_crc[31:4]};
            else if (w_crc_en)         r_crc <= w_crc_nxt;

            if (r_state == S_IDLE) begin
                r_bcnt <= '0;
                r_last <= 1'b0;
            end else if (w_acc && (r_state == S_SFD || r_state == S_DHI)) begin
                r_byte <= data;
                r_berr <= err;
                r_last <= last;
                if (r_bcnt != '1) r_bcnt <= r_bcnt + 11'd1;
            end else if (r_state == S_PHI) begin
                if (r_bcnt != '1) r_bcnt <= r_bcnt + 11'd1;
            end

            // The gap is counted from DISCARD entry, so a long drain shortens the IFG stay.
            if ((w_next == S_IFG || w_next == S_DISC) &&
                (r_state == S_FCS || r_state == S_JAM || r_state == S_UFL)) begin
                r_ifg <= IFG_N;
            end else if (r_ifg != '0) begin
                r_ifg <= r_ifg - 8'd1;
            end
        end
    end

    assign ready     = w_rdy && rst_n;
    assign tx_en     = r_tx_en;
    assign tx_er     = r_tx_er;
    assign txd       = r_txd;
    assign sent      = r_sent;
    assign collision = r_coll;
    assign underflow = r_ufl;

endmodule

// File: tb/tb_mii_mac_tx.sv
// Directed bench for mii_mac_tx: each scenario task captures the MII stream
// at the falling edge and checks it against hand-derived frame images.
module tb_mii_mac_tx;

    localparam int MAXC = 400;
    localparam int MIN  = 60;
    localparam int IFG  = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = '0;
    logic       valid = 1'b0, last = 1'b0, err = 1'b0, col = 1'b0;
    logic       ready, tx_en, tx_er, sent, collision, underflow;
    logic [3:0] txd;

    int total = 0;
    int bad   = 0;

    logic       cap_en [0:MAXC-1];
    logic       cap_er [0:MAXC-1];
    logic [3:0] cap_d  [0:MAXC-1];
    logic       cap_s  [0:MAXC-1];
    logic       cap_c  [0:MAXC-1];
    logic       cap_u  [0:MAXC-1];

    logic [7:0] g_pl  [0:127];
    logic [3:0] g_exp [0:255];
    int g_exp_n, g_len, g_err_idx, g_drop_idx, g_col_rel, g_rst_rel, g_t0, g_done, g_ncap;
    bit g_repeat;

    mii_mac_tx #(.MIN_DATA(60), .IFG_NIBBLES(24), .JAM_NIBBLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .last(last), .err(err),
        .ready(ready), .col(col), .tx_en(tx_en), .tx_er(tx_er), .txd(txd),
        .sent(sent), .collision(collision), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_model(input int nbytes);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < nbytes; k++) begin
            b = (k < g_len) ? g_pl[k] : 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp();
        int n;
        logic [31:0] fcs;
        logic [7:0]  b;
        n = (g_len < MIN) ? MIN : g_len;
        g_exp_n = 0;
        for (int k = 0; k < 15; k++) begin g_exp[g_exp_n] = 4'h5; g_exp_n++; end
        g_exp[g_exp_n] = 4'hD; g_exp_n++;
        for (int k = 0; k < n; k++) begin
            b = (k < g_len) ? g_pl[k] : 8'h00;
            g_exp[g_exp_n] = b[3:0]; g_exp_n++;
            g_exp[g_exp_n] = b[7:4]; g_exp_n++;
        end
        fcs = crc_model(n);
        for (int k = 0; k < 8; k++) begin g_exp[g_exp_n] = fcs[4*k +: 4]; g_exp_n++; end
    endtask

    function automatic int count_s(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k < hi && k < g_ncap; k++) if (cap_s[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int count_c(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k < hi && k < g_ncap; k++) if (cap_c[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int count_u(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k < hi && k < g_ncap; k++) if (cap_u[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int count_er(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k < hi && k < g_ncap; k++) if (cap_er[k] === 1'b1) n++;
        return n;
    endfunction
    function automatic int first_low(input int from);
        for (int k = from; k < g_ncap; k++) if (cap_en[k] !== 1'b1) return k;
        return -1;
    endfunction
    function automatic int next_rise(input int from);
        for (int k = from; k < g_ncap; k++) if (cap_en[k] === 1'b1) return k;
        return -1;
    endfunction
    // first index where the captured nibbles from 'start' differ from g_exp[0..n-1]
    function automatic int seq_bad(input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (start + k >= g_ncap) return k;
            if (cap_en[start+k] !== 1'b1 || cap_d[start+k] !== g_exp[k]) return k;
        end
        return -1;
    endfunction

    task automatic setup(input int len, input bit rep);
        g_len = len; g_repeat = rep;
        g_err_idx = -1; g_drop_idx = -1; g_col_rel = -1; g_rst_rel = -1;
        for (int k = 0; k < len; k++) g_pl[k] = 8'(k);
    endtask

    task automatic do_reset();
        valid = 1'b0; col = 1'b0; last = 1'b0; err = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int ncyc);
        int ptr;
        bit dropped;
        ptr = 0; dropped = 1'b0; g_t0 = -1; g_done = -1; g_ncap = ncyc;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cap_en[i] = tx_en; cap_er[i] = tx_er; cap_d[i] = txd;
            cap_s[i] = sent; cap_c[i] = collision; cap_u[i] = underflow;
            if (g_t0 < 0 && tx_en === 1'b1) g_t0 = i;
            rst_n = 1'b1;
            col = (g_t0 >= 0 && g_col_rel >= 0 && i == g_t0 + g_col_rel);
            if (g_t0 >= 0 && g_rst_rel >= 0 && i == g_t0 + g_rst_rel) begin
                rst_n = 1'b0; ptr = 0;
            end
            if (ptr < g_len) begin
                data = g_pl[ptr]; last = (ptr == g_len - 1); err = (ptr == g_err_idx); valid = 1'b1;
                if (ptr == g_drop_idx && ready === 1'b1 && !dropped) begin
                    valid = 1'b0; dropped = 1'b1;
                end
            end else begin
                valid = 1'b0; last = 1'b0; err = 1'b0; data = '0;
            end
            if (valid && ready === 1'b1 && rst_n) begin
                ptr++;
                if (ptr == g_len) begin
                    if (g_done < 0) g_done = i;
                    ptr = g_repeat ? 0 : g_len;
                end
            end
        end
        valid = 1'b0; col = 1'b0; last = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; data = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        total++; if (tx_er !== 1'b0) begin bad++; $display("FAIL reset_tx_er: got %b expected 0", tx_er); end
        total++; if (txd !== 4'h0) begin bad++; $display("FAIL reset_txd: got %h expected 0", txd); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        total++; if ({sent, collision, underflow} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b expected 000", {sent, collision, underflow});
        end
        valid = 1'b0;
        do_reset();
    endtask

    task automatic test_frame64();
        int t0, e, r, b;
        setup(64, 1'b1); build_exp(); run(220);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL f64_start: tx_en never rose"); return; end
        e = first_low(t0);
        total++; if (e - t0 != 152) begin bad++; $display("FAIL f64_width: got %0d expected 152", e - t0); end
        b = seq_bad(t0, g_exp_n);
        total++; if (b >= 0) begin
            bad++; $display("FAIL f64_nibbles: index %0d got %h expected %h", b, cap_d[t0+b], g_exp[b]);
        end
        total++; if (count_er(t0, e) != 0) begin bad++; $display("FAIL f64_tx_er: got %0d nibbles expected 0", count_er(t0, e)); end
        total++; if (count_s(t0, e + 5) != 1 || cap_s[t0+151] !== 1'b1) begin
            bad++; $display("FAIL f64_sent: count %0d at_last %b expected 1 and 1", count_s(t0, e + 5), cap_s[t0+151]);
        end
        total++; if (count_c(0, e + 5) + count_u(0, e + 5) != 0) begin
            bad++; $display("FAIL f64_other_pulses: got %0d expected 0", count_c(0, e + 5) + count_u(0, e + 5));
        end
        r = next_rise(e);
        total++; if (r < 0 || r - e < IFG || r - e > IFG + 2) begin
            bad++; $display("FAIL f64_ifg: gap %0d expected %0d..%0d", (r < 0) ? -1 : r - e, IFG, IFG + 2);
        end
        do_reset();
    endtask

    task automatic test_short_pad();
        int t0, e, b;
        setup(1, 1'b0); g_pl[0] = 8'hAB; build_exp(); run(170);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL pad_start: tx_en never rose"); return; end
        e = first_low(t0);
        total++; if (e - t0 != 144) begin bad++; $display("FAIL pad_width: got %0d expected 144", e - t0); end
        total++; if (cap_d[t0+16] !== 4'hB || cap_d[t0+17] !== 4'hA) begin
            bad++; $display("FAIL pad_first_byte: got %h%h expected ab", cap_d[t0+17], cap_d[t0+16]);
        end
        b = seq_bad(t0, g_exp_n);
        total++; if (b >= 0) begin
            bad++; $display("FAIL pad_nibbles: index %0d got %h expected %h", b, cap_d[t0+b], g_exp[b]);
        end
        total++; if (count_s(t0, g_ncap) != 1 || cap_s[t0+143] !== 1'b1) begin
            bad++; $display("FAIL pad_sent: count %0d at_last %b expected 1 and 1", count_s(t0, g_ncap), cap_s[t0+143]);
        end
        do_reset();
    endtask

    task automatic test_collision();
        int t0, e, r, jb;
        setup(64, 1'b1); g_col_rel = 20; run(170);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL col_start: tx_en never rose"); return; end
        jb = -1;
        for (int k = 22; k < 30; k++)
            if (jb < 0 && (cap_en[t0+k] !== 1'b1 || cap_er[t0+k] !== 1'b0 || cap_d[t0+k] !== 4'h5)) jb = k;
        total++; if (jb >= 0) begin
            bad++; $display("FAIL col_jam: nibble %0d got en=%b er=%b d=%h expected 1 0 5", jb, cap_en[t0+jb], cap_er[t0+jb], cap_d[t0+jb]);
        end
        e = first_low(t0);
        total++; if (e - t0 != 30) begin bad++; $display("FAIL col_end: tx_en fell at %0d expected 30", e - t0); end
        total++; if (count_c(0, e + 5) != 1 || cap_c[t0+22] !== 1'b1) begin
            bad++; $display("FAIL col_pulse: count %0d first_jam %b expected 1 and 1", count_c(0, e + 5), cap_c[t0+22]);
        end
        total++; if (count_s(0, e + 5) != 0) begin bad++; $display("FAIL col_sent: got %0d expected 0", count_s(0, e + 5)); end
        total++; if (g_done < 0) begin bad++; $display("FAIL col_drain: last byte accepted %0d expected yes", g_done); end
        r = next_rise(e);
        total++; if (r < 0 || r - e < IFG) begin
            bad++; $display("FAIL col_ifg: gap %0d expected >= %0d", (r < 0) ? -1 : r - e, IFG);
        end
        do_reset();
    endtask

    task automatic test_underflow();
        int t0, e, r, b;
        setup(12, 1'b1); g_drop_idx = 10; build_exp(); run(120);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL ufl_start: tx_en never rose"); return; end
        b = seq_bad(t0, 36);
        total++; if (b >= 0) begin
            bad++; $display("FAIL ufl_prefix: index %0d got %h expected %h", b, cap_d[t0+b], g_exp[b]);
        end
        total++; if (cap_en[t0+36] !== 1'b1 || cap_er[t0+36] !== 1'b1 || cap_d[t0+36] !== 4'h0) begin
            bad++; $display("FAIL ufl_nibble: got en=%b er=%b d=%h expected 1 1 0", cap_en[t0+36], cap_er[t0+36], cap_d[t0+36]);
        end
        e = first_low(t0);
        total++; if (e - t0 != 37) begin bad++; $display("FAIL ufl_end: tx_en fell at %0d expected 37", e - t0); end
        total++; if (count_u(0, e + 5) != 1 || cap_u[t0+36] !== 1'b1 || count_er(0, e) != 1) begin
            bad++; $display("FAIL ufl_pulse: count %0d at_nibble %b er_count %0d expected 1 1 1",
                            count_u(0, e + 5), cap_u[t0+36], count_er(0, e));
        end
        total++; if (count_s(0, e + 5) + count_c(0, e + 5) != 0) begin
            bad++; $display("FAIL ufl_other_pulses: got %0d expected 0", count_s(0, e + 5) + count_c(0, e + 5));
        end
        total++; if (g_done < 0) begin bad++; $display("FAIL ufl_drain: last byte accepted %0d expected yes", g_done); end
        r = next_rise(e);
        total++; if (r < 0 || r - e < IFG) begin
            bad++; $display("FAIL ufl_ifg: gap %0d expected >= %0d", (r < 0) ? -1 : r - e, IFG);
        end
        do_reset();
    endtask

    task automatic test_err_byte();
        int t0, e, b;
        setup(64, 1'b0); g_err_idx = 3; build_exp(); run(170);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL err_start: tx_en never rose"); return; end
        e = first_low(t0);
        total++; if (count_er(t0, e) != 2 || cap_er[t0+22] !== 1'b1 || cap_er[t0+23] !== 1'b1) begin
            bad++; $display("FAIL err_nibbles: count %0d lo %b hi %b expected 2 1 1", count_er(t0, e), cap_er[t0+22], cap_er[t0+23]);
        end
        b = seq_bad(t0, g_exp_n);
        total++; if (b >= 0) begin
            bad++; $display("FAIL err_fcs: index %0d got %h expected %h", b, cap_d[t0+b], g_exp[b]);
        end
        total++; if (count_s(t0, g_ncap) != 1) begin bad++; $display("FAIL err_sent: got %0d expected 1", count_s(t0, g_ncap)); end
        do_reset();
    endtask

    task automatic test_reset_fcs();
        int t0, r, e2, b;
        setup(64, 1'b0); g_rst_rel = 146; build_exp(); run(330);
        t0 = g_t0;
        total++; if (t0 < 0) begin bad++; $display("FAIL rstf_start: tx_en never rose"); return; end
        total++; if (cap_en[t0+147] !== 1'b0 || {cap_s[t0+147], cap_c[t0+147], cap_u[t0+147]} !== 3'b000) begin
            bad++; $display("FAIL rstf_cut: got en=%b pulses=%b expected 0 000", cap_en[t0+147],
                            {cap_s[t0+147], cap_c[t0+147], cap_u[t0+147]});
        end
        total++; if (count_s(0, t0 + 148) != 0) begin bad++; $display("FAIL rstf_no_sent: got %0d expected 0", count_s(0, t0 + 148)); end
        r = next_rise(t0 + 147);
        total++; if (r < 0 || r - (t0 + 147) >= IFG) begin
            bad++; $display("FAIL rstf_restart: delay %0d expected < %0d", (r < 0) ? -1 : r - (t0 + 147), IFG);
            do_reset(); return;
        end
        e2 = first_low(r);
        b = seq_bad(r, g_exp_n);
        total++; if (b >= 0 || e2 - r != 152) begin
            bad++; $display("FAIL rstf_frame2: first bad %0d width %0d expected -1 152", b, e2 - r);
        end
        total++; if (count_s(r, g_ncap) != 1) begin bad++; $display("FAIL rstf_sent2: got %0d expected 1", count_s(r, g_ncap)); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_frame64();
        test_short_pad();
        test_collision();
        test_underflow();
        test_err_byte();
        test_reset_fcs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
